sram_arbiter: RTL and testbench

- Shares the single SRAM controller port between two requesters: requester 0 (MEM stage load/store) and requester 1 (secondary master, e.g. instruction fetch or debug/DMA loader).
- Sits between the requesters and the SRAM controller's write_en/read_en/addr/st_val/read_data/ready interface.
- Latches the winning request, drives the controller until its ready completes the access, returns read data to the owner, then inserts idle gap cycles so the controller's wait FSM returns to IDLE.

---
 rtl/sram_arbiter_pkg.sv | 17 +
 rtl/sram_arbiter_pick.sv | 22 ++
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared state encodings and grant constants for the SRAM port arbiter
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_R0   = 2'b01;
  localparam logic [1:0] GRANT_R1   = 2'b10;

  // Word count of the SRAM behind the controller.
  localparam int SRAM_CNT = 1024;

endpackage

// File: rtl/sram_arbiter_pick.sv
// rtl/sram_arbiter_pick.sv - combinational one-hot winner select (fixed priority or round-robin)
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] i_pending,
  input  logic       i_last_r1,
  output logic [1:0] o_winner
);

  // Contention goes to whichever requester was not served last; a lone requester always wins.
  always_comb begin
    o_winner = GRANT_NONE;
    if (i_pending == 2'b11) begin
      o_winner = i_last_r1 ? GRANT_R0 : GRANT_R1;
    end else if (i_pending[0]) begin
      o_winner = GRANT_R0;
    end else if (i_pending[1]) begin
      o_winner = GRANT_R1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester arbiter for the SRAM controller port; SRAM_ARB_RR_EN selects round-robin
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_rd_en,
  input  logic              r0_wr_en,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_ready,
  input  logic              r1_rd_en,
  input  logic              r1_wr_en,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_ready,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  // Gap counter load value; legal GAP_CYCLES is 1..3 so two bits suffice.
  localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES - 1);

  arb_state_t        r_state;
  logic [1:0]        r_grant;
  logic              r_busy;
  logic              r_mem_rd_en;
  logic              r_mem_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_gap_cnt;

  logic [1:0]        w_pending;
  logic [1:0]        w_winner;
  logic              w_last_r1;
  logic              w_done;
  logic              w_win_wr;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  assign w_pending = {r1_rd_en | r1_wr_en, r0_rd_en | r0_wr_en};
  assign w_done    = (r_state == ST_BUSY) && mem_ready;

  // A write wins over a simultaneous read from the same requester.
  assign w_win_wr    = w_winner[1] ? r1_wr_en : r0_wr_en;
  assign w_win_addr  = w_winner[1] ? r1_addr  : r0_addr;
  assign w_win_wdata = w_winner[1] ? r1_wdata : r0_wdata;

`ifdef SRAM_ARB_RR_EN
  logic r_last_r1;

  // Remember who was served last; starts at r1 so r0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_r1 <= 1'b1;
    end else if (w_done) begin
      r_last_r1 <= r_grant[1];
    end
  end

  assign w_last_r1 = r_last_r1;
`else
  // Pretending r1 was always served last makes the selector plain r0-first priority.
  assign w_last_r1 = 1'b1;
`endif

  sram_arb_pick u_pick (
    .i_pending (w_pending),
    .i_last_r1 (w_last_r1),
    .o_winner  (w_winner)
  );

  // Arbitration FSM: latch the winner in IDLE, hold the controller in BUSY, idle it in GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= GRANT_NONE;
      r_busy      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_gap_cnt   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_pending) begin
            r_grant     <= w_winner;
            r_addr      <= w_win_addr;
            r_wdata     <= w_win_wdata;
            r_mem_wr_en <= w_win_wr;
            r_mem_rd_en <= ~w_win_wr;
            r_busy      <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            r_grant     <= GRANT_NONE;
            r_mem_wr_en <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_gap_cnt   <= GAP_LOAD;
            r_state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 2'd0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 2'd1;
          end
        end
        default: begin
          r_grant     <= GRANT_NONE;
          r_busy      <= 1'b0;
          r_mem_wr_en <= 1'b0;
          r_mem_rd_en <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en = r_mem_rd_en;
  assign mem_wr_en = r_mem_wr_en;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign grant     = r_grant;
  assign busy      = r_busy;

  // Idle requesters see ready; a requesting one only in its own completion cycle.
  assign r0_ready = ~w_pending[0] | (w_done & r_grant[0]);
  assign r1_ready = ~w_pending[1] | (w_done & r_grant[1]);

  assign r0_rdata = r_grant[0] ? mem_rdata : '0;
  assign r1_rdata = r_grant[1] ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed table-driven bench for sram_arbiter
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int GAP       = 1;
  localparam int SRAM_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_rd_en = 1'b0, r0_wr_en = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic [31:0] r0_rdata;
  logic        r0_ready;
  logic        r1_rd_en = 1'b0, r1_wr_en = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic [31:0] r1_rdata;
  logic        r1_ready;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .r0_rd_en(r0_rd_en), .r0_wr_en(r0_wr_en), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rdata(r0_rdata), .r0_ready(r0_ready),
    .r1_rd_en(r1_rd_en), .r1_wr_en(r1_wr_en), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rdata(r1_rdata), .r1_ready(r1_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy)
  );

  // SRAM controller model: ready after SRAM_WAIT enabled cycles, write lands on the ready edge.
  logic [31:0] mem_arr [SRAM_CNT];
  int          m_cnt;
  logic [9:0]  m_idx;
  assign m_idx     = mem_addr[11:2];
  assign mem_ready = (mem_rd_en || mem_wr_en) && (m_cnt == SRAM_WAIT);
  assign mem_rdata = mem_arr[m_idx];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
    end else if (mem_rd_en || mem_wr_en) begin
      if (mem_ready) begin
        m_cnt <= 0;
        if (mem_wr_en) mem_arr[m_idx] <= mem_wdata;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (!busy && grant == GRANT_NONE) seen = 1;
    end
    chk("wait_idle", seen, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_txn(input int req, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
    bit done = 0;
    rdata = '0;
    @(posedge clk); #1;
    if (req == 0) begin
      r0_rd_en = rd; r0_wr_en = wr; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_rd_en = rd; r1_wr_en = wr; r1_addr = addr; r1_wdata = wdata;
    end
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if ((req == 0) ? r0_ready : r1_ready) begin
        done  = 1;
        rdata = (req == 0) ? r0_rdata : r1_rdata;
        chk("txn_grant", grant, (req == 0) ? GRANT_R0 : GRANT_R1);
      end
    end
    chk("txn_done", done, 1);
    @(posedge clk); #1;
    r0_rd_en = 1'b0; r0_wr_en = 1'b0; r1_rd_en = 1'b0; r1_wr_en = 1'b0;
    wait_idle();
  endtask

  typedef struct {
    logic       r0_wr;
    logic       exp_wr_en;
    logic [1:0] exp_grant;
    logic       exp_busy;
    logic       exp_r0_ready;
    logic       exp_r1_ready;
  } cyc_vec_t;

  typedef struct {
    int          req;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } txn_vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    cyc_vec_t    cv [6];
    txn_vec_t    tv [7];
    logic [31:0] rd_val;
    logic [1:0]  exp_order [4];

    // r0 write 1024/50 alone: IDLE, 3 BUSY cycles (ready on the third), 1 GAP, IDLE.
    cv[0] = '{1'b1, 1'b0, GRANT_NONE, 1'b0, 1'b0, 1'b1};
    cv[1] = '{1'b1, 1'b1, GRANT_R0,   1'b1, 1'b0, 1'b1};
    cv[2] = '{1'b1, 1'b1, GRANT_R0,   1'b1, 1'b0, 1'b1};
    cv[3] = '{1'b1, 1'b1, GRANT_R0,   1'b1, 1'b1, 1'b1};
    cv[4] = '{1'b0, 1'b0, GRANT_NONE, 1'b1, 1'b1, 1'b1};
    cv[5] = '{1'b0, 1'b0, GRANT_NONE, 1'b0, 1'b1, 1'b1};

    tv[0] = '{1, 1'b0, 1'b1, 32'd16,   32'hA5A5_A5A5, 1'b0, 32'h0};
    tv[1] = '{0, 1'b0, 1'b1, 32'd20,   32'h5A5A_5A5A, 1'b0, 32'h0};
    tv[2] = '{1, 1'b1, 1'b0, 32'd20,   32'h0,         1'b1, 32'h5A5A_5A5A};
    tv[3] = '{0, 1'b1, 1'b0, 32'd16,   32'h0,         1'b1, 32'hA5A5_A5A5};
    tv[4] = '{0, 1'b1, 1'b1, 32'd4,    32'd7,         1'b0, 32'h0};
    tv[5] = '{1, 1'b1, 1'b0, 32'd4,    32'h0,         1'b1, 32'd7};
    tv[6] = '{0, 1'b1, 1'b0, 32'd1024, 32'h0,         1'b1, 32'd50};

`ifdef SRAM_ARB_RR_EN
    exp_order = '{GRANT_R0, GRANT_R1, GRANT_R0, GRANT_R1};
`else
    exp_order = '{GRANT_R0, GRANT_R0, GRANT_R0, GRANT_R0};
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, GRANT_NONE);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_r0_ready", r0_ready, 1);
    chk("rst_r1_ready", r1_ready, 1);
    rst = 1'b0;

    // Cycle-by-cycle single write.
    r0_addr = 32'd1024; r0_wdata = 32'd50;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      r0_wr_en = cv[i].r0_wr;
      @(negedge clk);
      chk($sformatf("t1_wr_en[%0d]", i), mem_wr_en, cv[i].exp_wr_en);
      chk($sformatf("t1_rd_en[%0d]", i), mem_rd_en, 0);
      chk($sformatf("t1_grant[%0d]", i), grant, cv[i].exp_grant);
      chk($sformatf("t1_busy[%0d]", i), busy, cv[i].exp_busy);
      chk($sformatf("t1_r0_ready[%0d]", i), r0_ready, cv[i].exp_r0_ready);
      chk($sformatf("t1_r1_ready[%0d]", i), r1_ready, cv[i].exp_r1_ready);
    end
    wait_idle();
    chk("t1_mem", mem_arr[256], 32'd50);

    // Transaction table, including rd+wr together (write wins).
    do_txn(1, 1'b0, 1'b1, 32'd1028, 32'h1234_5678, rd_val);
    for (int i = 0; i < 7; i++) begin
      do_txn(tv[i].req, tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata, rd_val);
      if (tv[i].chk_rd) chk($sformatf("txn_rdata[%0d]", i), rd_val, tv[i].exp_rdata);
    end
    chk("rdwr_mem", mem_arr[1], 32'd7);

    // Simultaneous reads: r0 first, r1 granted after the gap.
    do_reset();
    begin
      int k0 = -1, g1 = -1, n0 = 0, n1 = 0;
      bit drop0, drop1;
      @(posedge clk); #1;
      r0_rd_en = 1'b1; r0_addr = 32'd1024;
      r1_rd_en = 1'b1; r1_addr = 32'd1028;
      for (int c = 0; c < 80 && (r0_rd_en || r1_rd_en); c++) begin
        @(negedge clk);
        if (g1 < 0 && grant == GRANT_R1) g1 = c;
        drop0 = r0_rd_en && r0_ready;
        drop1 = r1_rd_en && r1_ready;
        if (drop0) begin
          n0++; k0 = c;
          chk("t2_r0_grant", grant, GRANT_R0);
          chk("t2_r0_rdata", r0_rdata, 32'd50);
        end
        if (drop1) begin
          n1++;
          chk("t2_r1_after_r0", (k0 >= 0), 1);
          chk("t2_r1_rdata", r1_rdata, 32'h1234_5678);
        end
        @(posedge clk); #1;
        if (drop0) r0_rd_en = 1'b0;
        if (drop1) r1_rd_en = 1'b0;
      end
      chk("t2_r0_once", n0, 1);
      chk("t2_r1_once", n1, 1);
      // Completion k, GAP k+1..k+GAP, IDLE decision next, grant register visible one after.
      chk("t2_r1_grant_cycle", g1, k0 + GAP + 2);
      r0_rd_en = 1'b0; r1_rd_en = 1'b0;
      wait_idle();
    end

    // r1 write withdrawn one cycle into BUSY still completes from the latched copy.
    begin
      bit done = 0;
      @(posedge clk); #1;
      r1_wr_en = 1'b1; r1_addr = 32'd8; r1_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      chk("t5_grant", grant, GRANT_R1);
      chk("t5_wr_en", mem_wr_en, 1);
      @(posedge clk); #1;
      r1_wr_en = 1'b0; r1_addr = 32'd0; r1_wdata = 32'd0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (mem_ready) begin
          done = 1;
          chk("t5_addr", mem_addr, 32'd8);
          chk("t5_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
      end
      chk("t5_done", done, 1);
      wait_idle();
      chk("t5_mem", mem_arr[2], 32'hDEAD_BEEF);
      do_txn(0, 1'b1, 1'b0, 32'd8, 32'h0, rd_val);
      chk("t5_readback", rd_val, 32'hDEAD_BEEF);
    end

    // Asynchronous reset mid-BUSY, then a held r0 request is granted on the first edge.
    begin
      bit done = 0;
      @(posedge clk); #1;
      r0_wr_en = 1'b1; r0_addr = 32'd12; r0_wdata = 32'd99;
      @(negedge clk);
      @(negedge clk);
      chk("t6_wr_en_before", mem_wr_en, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_wr_en_rst", mem_wr_en, 0);
      chk("t6_rd_en_rst", mem_rd_en, 0);
      chk("t6_grant_rst", grant, GRANT_NONE);
      chk("t6_busy_rst", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_regrant", grant, GRANT_R0);
      chk("t6_wr_en_after", mem_wr_en, 1);
      for (int c = 0; c < 20 && !done; c++) begin
        if (r0_ready) done = 1;
        else @(negedge clk);
      end
      chk("t6_done", done, 1);
      @(posedge clk); #1;
      r0_wr_en = 1'b0;
      wait_idle();
    end

    // Both requesters hold reads across four transactions.
    do_reset();
    begin
      logic [1:0] prev = GRANT_NONE;
      logic [1:0] order [4];
      int n = 0;
      @(posedge clk); #1;
      r0_rd_en = 1'b1; r0_addr = 32'd0;
      r1_rd_en = 1'b1; r1_addr = 32'd4;
      for (int c = 0; c < 200 && n < 4; c++) begin
        @(negedge clk);
        if (prev == GRANT_NONE && grant != GRANT_NONE) begin
          order[n] = grant;
          n++;
        end
        prev = grant;
      end
      @(posedge clk); #1;
      r0_rd_en = 1'b0; r1_rd_en = 1'b0;
      wait_idle();
      chk("t4_count", n, 4);
      for (int i = 0; i < 4; i++) begin
        if (i < n) chk($sformatf("t4_order[%0d]", i), order[i], exp_order[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
